// File: rtl/score_pkg.sv
// Shared definitions for the score event scheduler: grade encodings, point
// lookup and default combo/multiplier constants.
package score_pkg;

  typedef enum logic [1:0] {
    GRADE_OK      = 2'd0,
    GRADE_GOOD    = 2'd1,
    GRADE_PERFECT = 2'd2,
    GRADE_RSVD    = 2'd3
  } grade_e;

  localparam int COMBO_SAT      = 999;
  localparam int DEF_MAX_MULT   = 4;
  localparam int DEF_COMBO_STEP = 10;

  function automatic logic [1:0] grade_points(input logic [1:0] grade);
    logic [1:0] pts;
    unique case (grade_e'(grade))
      GRADE_OK:      pts = 2'd1;
      GRADE_GOOD:    pts = 2'd2;
      GRADE_PERFECT: pts = 2'd3;
      default:       pts = 2'd0;
    endcase
    return pts;
  endfunction

endpackage

// File: rtl/score_event_scheduler_if.sv
// Judgement-side event bus into the scheduler plus its score/status outputs.
interface score_event_scheduler_if #(
  parameter int N_LANES = 4,
  parameter int COMBO_W = 10
);
  logic                   enable;
  logic [N_LANES-1:0]     hit_valid;
  logic [2*N_LANES-1:0]   hit_grade;
  logic [N_LANES-1:0]     miss;
  logic                   score_inc;
  logic [COMBO_W-1:0]     combo;
  logic [2:0]             multiplier;
  logic                   busy;
  logic                   overflow;

  modport master (
    output enable, hit_valid, hit_grade, miss,
    input  score_inc, combo, multiplier, busy, overflow
  );

  modport slave (
    input  enable, hit_valid, hit_grade, miss,
    output score_inc, combo, multiplier, busy, overflow
  );
endinterface

// File: rtl/score_event_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches from the lane after the last grant, one-hot
// grant per cycle, pointer only moves when something is granted.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         grant_any
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  int               idx;

  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    ptr_d     = ptr_q;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!grant_any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_any  = 1'b1;
        ptr_d      = PTR_W'(idx);
      end
    end
  end

  // Reset pointer at the last lane so lane 0 is searched first.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= PTR_W'(N - 1);
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/score_event_scheduler.sv
// Collects per-lane hit/miss events, tracks combo and multiplier, and drains
// per-lane pending points as single-cycle score_inc pulses.
module score_event_scheduler
  import score_pkg::*;
#(
  parameter int N_LANES    = 4,
  parameter int PEND_W     = 6,
  parameter int COMBO_STEP = DEF_COMBO_STEP,
  parameter int MAX_MULT   = DEF_MAX_MULT,
  parameter int COMBO_W    = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  score_event_scheduler_if.slave    ev
);

  localparam int PEND_MAX = (1 << PEND_W) - 1;

  logic [PEND_W-1:0]  pending_q [N_LANES];
  logic [PEND_W-1:0]  pending_d [N_LANES];
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic               score_inc_q, score_inc_d;
  logic               overflow_q, overflow_d;

  logic [2:0]         mult;
  int                 mult_raw;
  int                 hit_cnt;
  int                 combo_sum;
  int                 pend_sum;
  logic [N_LANES-1:0] pend_nz;
  logic [N_LANES-1:0] req;
  logic [N_LANES-1:0] grant;
  logic               grant_any;

  always_comb begin
    mult_raw = int'(combo_q) / COMBO_STEP + 1;
    if (mult_raw > MAX_MULT) mult_raw = MAX_MULT;
    mult = 3'(mult_raw);
  end

  // Reserved grades neither score nor extend the streak.
  always_comb begin
    hit_cnt = 0;
    for (int i = 0; i < N_LANES; i++) begin
      if (ev.hit_valid[i] && (ev.hit_grade[2*i +: 2] != GRADE_RSVD)) hit_cnt = hit_cnt + 1;
    end
    combo_sum = int'(combo_q) + hit_cnt;
    if (combo_sum > COMBO_SAT) combo_sum = COMBO_SAT;
    combo_d = (|ev.miss) ? '0 : COMBO_W'(combo_sum);
  end

  always_comb begin
    overflow_d = overflow_q;
    pend_sum   = 0;
    for (int i = 0; i < N_LANES; i++) begin
      pend_sum = int'(pending_q[i]);
      if (ev.hit_valid[i]) pend_sum = pend_sum + int'(grade_points(ev.hit_grade[2*i +: 2])) * int'(mult);
      if (grant[i]) pend_sum = pend_sum - 1;
      if (pend_sum > PEND_MAX) begin
        pend_sum   = PEND_MAX;
        overflow_d = 1'b1;
      end
      pending_d[i] = PEND_W'(pend_sum);
      pend_nz[i]   = (pending_q[i] != '0);
      req[i]       = pend_nz[i] && ev.enable;
    end
  end

  rr_arbiter #(.N(N_LANES)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .grant     (grant),
    .grant_any (grant_any)
  );

  assign score_inc_d = grant_any;

  always_ff @(posedge clk) begin
    if (reset) begin
      combo_q     <= '0;
      score_inc_q <= 1'b0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < N_LANES; i++) pending_q[i] <= '0;
    end else begin
      combo_q     <= combo_d;
      score_inc_q <= score_inc_d;
      overflow_q  <= overflow_d;
      for (int i = 0; i < N_LANES; i++) pending_q[i] <= pending_d[i];
    end
  end

  assign ev.score_inc  = score_inc_q;
  assign ev.combo      = combo_q;
  assign ev.multiplier = mult;
  assign ev.overflow   = overflow_q;
  assign ev.busy       = score_inc_q | (|pend_nz);

endmodule

// File: tb/tb_score_event_scheduler.sv
// Directed bench for score_event_scheduler: latency, multiplier steps,
// round-robin order, miss handling, saturation/overflow and mid-drain reset.
module tb_score_event_scheduler;
  import score_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  score_event_scheduler_if #(.N_LANES(N), .COMBO_W(10)) ev ();

  score_event_scheduler #(
    .N_LANES(N), .PEND_W(6), .COMBO_STEP(10), .MAX_MULT(4), .COMBO_W(10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ev    (ev)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int pulse_cnt = 0;
  int glog[$];
  bit glog_on = 1'b0;
  logic [31:0] pat;
  logic [31:0] bz;
  int base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  // Advance to 1 time unit after the next rising edge and sample there.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ev.score_inc === 1'b1) pulse_cnt++;
    if (glog_on && dut.u_arb.grant_any)
      for (int i = 0; i < N; i++) if (dut.u_arb.grant[i]) glog.push_back(i);
  endtask

  task automatic clear_in();
    ev.hit_valid = '0;
    ev.hit_grade = '0;
    ev.miss      = '0;
  endtask

  task automatic drive(input logic [N-1:0] hv, input logic [2*N-1:0] hg, input logic [N-1:0] ms);
    ev.hit_valid = hv;
    ev.hit_grade = hg;
    ev.miss      = ms;
    tick();
    clear_in();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ev.enable = 1'b1;
    clear_in();
    tick();
    tick();
    reset = 1'b0;
    pulse_cnt = 0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (ev.busy !== 1'b1) break;
      tick();
    end
    chk(tag, ev.busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    ev.enable = 1'b1;
    clear_in();
    do_reset();

    chk("rst_score_inc", ev.score_inc, 0);
    chk("rst_combo", ev.combo, 0);
    chk("rst_mult", ev.multiplier, 1);
    chk("rst_busy", ev.busy, 0);
    chk("rst_overflow", ev.overflow, 0);

    // Single PERFECT on lane 0: pulses in n+2..n+4, busy n+1..n+4.
    ev.hit_valid = 4'b0001;
    ev.hit_grade = 8'h02;
    pat = '0; bz = '0;
    pat[0] = ev.score_inc; bz[0] = ev.busy;
    tick();
    clear_in();
    for (int k = 1; k < 8; k++) begin
      pat[k] = ev.score_inc; bz[k] = ev.busy;
      tick();
    end
    chk("t1_pulse_pattern", pat, 32'h1C);
    chk("t1_busy_pattern", bz, 32'h1E);
    chk("t1_combo", ev.combo, 1);
    chk("t1_pulses", pulse_cnt, 3);

    // Ten OK hits on lane 1, then PERFECT at multiplier 2.
    do_reset();
    for (int h = 0; h < 10; h++) begin
      drive(4'b0010, 8'h00, 4'b0000);
      repeat (4) tick();
    end
    chk("t2_combo10", ev.combo, 10);
    chk("t2_mult2", ev.multiplier, 2);
    chk("t2_pulses_ok", pulse_cnt, 10);
    pulse_cnt = 0;
    drive(4'b0010, 8'h08, 4'b0000);
    wait_drain("t2_drain");
    chk("t2_pulses_perfect", pulse_cnt, 6);
    chk("t2_combo11", ev.combo, 11);

    // GOOD on all lanes: 8 back-to-back pulses in lane order 0,1,2,3,0,1,2,3.
    do_reset();
    glog.delete();
    glog_on = 1'b1;
    ev.hit_valid = 4'b1111;
    ev.hit_grade = 8'h55;
    pat = '0;
    pat[0] = ev.score_inc;
    tick();
    clear_in();
    for (int k = 1; k < 12; k++) begin
      pat[k] = ev.score_inc;
      tick();
    end
    glog_on = 1'b0;
    chk("t3_pulse_pattern", pat, 32'h3FC);
    chk("t3_grant_count", glog.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < glog.size()) chk($sformatf("t3_grant%0d", i), glog[i], i % 4);
    chk("t3_combo", ev.combo, 4);

    // Build combo to 23, then miss on lane 2 with GOOD hit on lane 0.
    do_reset();
    repeat (5) drive(4'b1111, 8'h55, 4'b0000);
    drive(4'b0111, 8'h00, 4'b0000);
    wait_drain("t4_drain_a");
    chk("t4_combo23", ev.combo, 23);
    chk("t4_mult3", ev.multiplier, 3);
    pulse_cnt = 0;
    drive(4'b0001, 8'h01, 4'b0100);
    chk("t4_combo_cleared", ev.combo, 0);
    chk("t4_mult_reset", ev.multiplier, 1);
    wait_drain("t4_drain_b");
    chk("t4_pulses", pulse_cnt, 6);

    // Paused: 30 PERFECT on lane 3 at multiplier 4 saturates pending at 63.
    do_reset();
    repeat (8) drive(4'b1111, 8'h00, 4'b0000);
    wait_drain("t5_drain_a");
    chk("t5_mult4", ev.multiplier, 4);
    chk("t5_overflow_before", ev.overflow, 0);
    ev.enable = 1'b0;
    pulse_cnt = 0;
    repeat (30) drive(4'b1000, 8'h80, 4'b0000);
    repeat (2) tick();
    chk("t5_overflow", ev.overflow, 1);
    chk("t5_paused_pulses", pulse_cnt, 0);
    chk("t5_busy_paused", ev.busy, 1);
    ev.enable = 1'b1;
    wait_drain("t5_drain_b");
    chk("t5_pulses", pulse_cnt, 63);
    chk("t5_overflow_sticky", ev.overflow, 1);

    // Reset after 3 pulses with two lanes pending.
    do_reset();
    drive(4'b0011, 8'h0A, 4'b0000);
    for (int i = 0; i < 40; i++) begin
      if (pulse_cnt >= 3) break;
      tick();
    end
    chk("t6_pulses_before", pulse_cnt, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_score_inc", ev.score_inc, 0);
    chk("t6_busy", ev.busy, 0);
    chk("t6_combo", ev.combo, 0);
    base = pulse_cnt;
    repeat (20) tick();
    chk("t6_no_late_pulses", pulse_cnt - base, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/score_event_scheduler.md
Name: score_event_scheduler

Overview:
- Sits between the note-judgement logic and the six-digit BCD/ASCII score counter, which accepts at most one +1 pulse per clock.
- Collects hit/miss events from N_LANES note lanes and tracks the combo streak and score multiplier.
- Converts each awarded hit into a per-lane pending point count and drains the pending counts with a round-robin arbiter as single-cycle score_inc pulses.

Parameters:
- N_LANES, 4, number of note lanes (requesters), 2..8.
- PEND_W, 6, width of each lane's pending-point counter; saturates at 2^PEND_W-1.
- COMBO_STEP, 10, consecutive hits per multiplier step.
- MAX_MULT, 4, multiplier ceiling, 1..7.
- COMBO_W, 10, combo counter width; saturates at 999.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; clears all state.
- enable  in  1  1 = drain pending points; 0 = paused (events still accepted, no pulses).
- hit_valid  in  N_LANES  per-lane single-cycle hit strobe.
- hit_grade  in  2*N_LANES  per-lane grade, lane i at bits [2i+1:2i], sampled with hit_valid[i].
- miss  in  N_LANES  per-lane single-cycle miss strobe.
- score_inc  out  1  registered +1 pulse to the score counter.
- combo  out  COMBO_W  current streak, binary.
- multiplier  out  3  current multiplier, 1..MAX_MULT.
- busy  out  1  any pending count nonzero or score_inc high.
- overflow  out  1  sticky; a lane's pending counter saturated.

Behaviour:
- Reset values: score_inc=0, combo=0, multiplier=1, busy=0, overflow=0, all pending=0, RR pointer=N_LANES-1 so lane 0 is searched first.
- Grade points: 0 OK=1, 1 GOOD=2, 2 PERFECT=3, 3 reserved=0. A reserved grade awards nothing and does not change combo.
- Multiplier: min(1 + combo/COMBO_STEP, MAX_MULT), computed from the registered combo.
- award_i = points(grade_i) * multiplier, using the multiplier held at the start of that cycle.
- Combo update per cycle:
  - If any miss bit is set: combo <= 0.
  - Else: combo <= sat(combo + popcount of valid non-reserved hits), ceiling 999.
- Miss and hit on the same lane in the same cycle: the hit is still awarded, and the miss still clears combo.
- Pending update per lane: pending_i <= sat(pending_i + award_i - granted_i).
  - The add and the grant-decrement may occur in the same cycle.
  - Any clipping at the ceiling sets overflow. overflow clears only on reset.
- Arbiter:
  - Active only when enable=1.
  - Searches lanes from RR pointer+1 upward, wrapping, for pending_i != 0.
  - Grants one lane per cycle, decrements that lane, and sets the pointer to the granted lane.
  - No grant: pointer is held.
- score_inc <= grant_any. Sustained throughput is one pulse per cycle while any lane has pending points.
- Latency: hit_valid in cycle n, with no other lane pending, gives the first score_inc in cycle n+2.
- enable low: no grants, score_inc=0 from the next cycle, pending counts retained, pointer held. Draining resumes in the cycle after enable returns high.
- reset mid-drain: pending counts are discarded, score_inc=0 the following cycle, and no further pulses are issued. The score counter's own reset is driven by the same signal.
- busy is combinational: OR of all pending != 0 and score_inc.

Decomposition:
- Shared package score_pkg:
  - grade encodings GRADE_OK/GOOD/PERFECT/RSVD
  - points lookup function
  - COMBO_SAT=999
  - default MAX_MULT/COMBO_STEP constants
- One sub-module: rr_arbiter (N-way request vector, registered pointer, one-hot grant, grant_any). It is reused later for other shared display resources.

Test Plan:
- Single PERFECT on lane 0 at combo 0, enable=1 in cycle n -> score_inc high in cycles n+2, n+3, n+4 only; combo=1; busy low from n+5.
- 10 OK hits on lane 1 (one per 5 cycles), then PERFECT -> multiplier reads 2 after the 10th; the 11th hit yields 6 pulses; combo=11.
- GOOD on lanes 0-3 in the same cycle at multiplier 1 -> 8 consecutive pulses, grants in lane order 0,1,2,3,0,1,2,3; combo +4.
- Miss on lane 2 with combo=23 together with a hit on lane 0 -> lane-0 hit awarded at multiplier 3; combo=0 and multiplier=1 next cycle.
- enable=0, then 30 PERFECT hits on lane 3 at multiplier 4 (PEND_W=6) -> pending saturates at 63 and overflow=1. enable=1 then gives exactly 63 pulses.
- Pending points on 2 lanes, reset asserted after 3 pulses -> score_inc=0 from the next cycle, busy=0, combo=0, no later pulses.
